// File: rtl/rev_code_if.sv
// Sensor/range-FSM side signals of the tachometer revolution-code encoder.
// master = the environment driving en/pulse_in, slave = the encoder.
interface rev_code_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             pulse_in;
  logic [1:0]       R;
  logic             A;
  logic             upd;
  logic [CNT_W-1:0] count;

  modport master (output en, output pulse_in, input R, input A, input upd, input count);
  modport slave  (input en, input pulse_in, output R, output A, output upd, output count);
endinterface

// File: rtl/rev_code_encoder.sv
// Tachometer front end: counts synchronized pulse edges per gate window and maps the
// count to the revolution code R / on-off flag A. Optional input filter: TACH_DEBOUNCE_EN.
module rev_code_encoder #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int CNT_W         = 8,
  parameter int TH1           = 10,
  parameter int TH2           = 40,
  parameter int TH3           = 80,
  parameter int DEB_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       reset,
  rev_code_if.slave  bus
);

  localparam int WCNT_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WINDOW_CYCLES - 1);
  localparam logic [31:0] TH1_U = 32'(TH1);
  localparam logic [31:0] TH2_U = 32'(TH2);
  localparam logic [31:0] TH3_U = 32'(TH3);

  if (WINDOW_CYCLES < 4 || TH1 >= TH2 || TH2 >= TH3 || DEB_CYCLES < 1) begin : g_param_err
    $error("rev_code_encoder: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARM     = 2'b01,
    MEASURE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] final_s;
  logic [1:0]       r_q, r_d;
  logic             a_q, a_d;
  logic             upd_q, upd_d;

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic edge_q, edge_d;
  logic level_s;

`ifdef TACH_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  logic             filt_q, filt_d;
  logic [DEB_W-1:0] deb_q, deb_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic e);
    if (e && (c != {CNT_W{1'b1}})) begin
      return c + CNT_W'(1);
    end else begin
      return c;
    end
  endfunction

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] c);
    logic [31:0] cw;
    cw = 32'(c);
    if (cw >= TH3_U) begin
      return 2'b11;
    end else if (cw >= TH2_U) begin
      return 2'b10;
    end else if (cw >= TH1_U) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Input path: 2-flop synchronizer, optional level filter, rising-edge detector.
  always_comb begin
    sync1_d = bus.pulse_in;
    sync2_d = sync1_q;
`ifdef TACH_DEBOUNCE_EN
    filt_d = filt_q;
    deb_d  = deb_q;
    if (state_q == IDLE) begin
      filt_d = 1'b0;
      deb_d  = '0;
    end else if (sync2_q != filt_q) begin
      if (deb_q == DEB_LAST) begin
        filt_d = sync2_q;
        deb_d  = '0;
      end else begin
        deb_d = deb_q + DEB_W'(1);
      end
    end else begin
      deb_d = '0;
    end
    level_s = filt_q;
`else
    level_s = sync2_q;
`endif
    prev_d = level_s;
    edge_d = level_s & ~prev_q;
  end

  // Input path registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
`ifdef TACH_DEBOUNCE_EN
      filt_q  <= 1'b0;
      deb_q   <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
`ifdef TACH_DEBOUNCE_EN
      filt_q  <= filt_d;
      deb_q   <= deb_d;
`endif
    end
  end

  // Window sequencing and output next-state; en low overrides everything, even a closing window.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pcnt_d  = pcnt_q;
    count_d = count_q;
    r_d     = r_q;
    a_d     = a_q;
    upd_d   = 1'b0;
    final_s = sat_inc(pcnt_q, edge_q);
    if (!bus.en) begin
      state_d = IDLE;
      wcnt_d  = '0;
      pcnt_d  = '0;
      count_d = '0;
      r_d     = 2'b00;
      a_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          wcnt_d  = '0;
          pcnt_d  = '0;
          count_d = '0;
          r_d     = 2'b00;
          a_d     = 1'b1;
        end
        ARM: begin
          state_d = MEASURE;
          wcnt_d  = '0;
          pcnt_d  = '0;
          a_d     = 1'b1;
        end
        MEASURE: begin
          a_d = 1'b1;
          if (wcnt_q == WLAST) begin
            wcnt_d  = '0;
            pcnt_d  = '0;
            count_d = final_s;
            r_d     = classify(final_s);
            upd_d   = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
            pcnt_d = final_s;
          end
        end
        default: begin
          state_d = IDLE;
          wcnt_d  = '0;
          pcnt_d  = '0;
          count_d = '0;
          r_d     = 2'b00;
          a_d     = 1'b0;
        end
      endcase
    end
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      pcnt_q  <= '0;
      count_q <= '0;
      r_q     <= 2'b00;
      a_q     <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      r_q     <= r_d;
      a_q     <= a_d;
      upd_q   <= upd_d;
    end
  end

  assign bus.R     = r_q;
  assign bus.A     = a_q;
  assign bus.upd   = upd_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_rev_code_encoder.sv
// Directed self-checking bench for rev_code_encoder (default build, no input filter).
module tb_rev_code_encoder;
  localparam int W  = 100;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rev_code_if #(.CNT_W(CW)) bus ();

  rev_code_encoder #(
    .WINDOW_CYCLES(W), .CNT_W(CW), .TH1(2), .TH2(5), .TH3(8), .DEB_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int extra_upd;
  int ncyc;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the upd cycle (window offset 0); returns in the next window's offset-0 cycle.
  task automatic run_window(input int npulses, input int start, input int period, input int hi);
    int off;
    extra_upd = 0;
    for (int c = 0; c < W; c++) begin
      off = c - start;
      bus.pulse_in = (off >= 0) && (off / period < npulses) && (off % period < hi);
      tick();
      if (c < W - 1 && bus.upd) extra_upd++;
    end
    bus.pulse_in = 1'b0;
  endtask

  task automatic check_win(input string tag, input int exp_r, input int exp_cnt);
    check_eq({tag, "_upd"}, int'(bus.upd), 1);
    check_eq({tag, "_R"}, int'(bus.R), exp_r);
    check_eq({tag, "_count"}, int'(bus.count), exp_cnt);
    check_eq({tag, "_A"}, int'(bus.A), 1);
    check_eq({tag, "_extra_upd"}, extra_upd, 0);
  endtask

  task automatic wait_upd(output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      cycles++;
      if (bus.upd) seen = 1'b1;
    end
    check_eq("upd_timeout", int'(seen), 1);
  endtask

  task automatic check_off(input string tag);
    check_eq({tag, "_A"}, int'(bus.A), 0);
    check_eq({tag, "_R"}, int'(bus.R), 0);
    check_eq({tag, "_count"}, int'(bus.count), 0);
    check_eq({tag, "_upd"}, int'(bus.upd), 0);
  endtask

  task automatic check_quiet(input string tag);
    int u;
    u = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (bus.upd || bus.A) u++;
    end
    check_eq(tag, u, 0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.pulse_in = 1'b0;
    repeat (3) tick();
    check_off("reset");

    // Get a live non-zero code, then hit reset mid-window.
    reset = 1'b0;
    tick();
    bus.en = 1'b1;
    wait_upd(ncyc);
    run_window(3, 2, 10, 5);
    check_win("pre_reset", 1, 3);
    repeat (40) tick();
    #2;
    reset = 1'b1;
    #1;
    check_off("reset_mid");
    bus.en = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Enable with no pulses: A after two edges, first upd after ARM + one full window.
    bus.en = 1'b1;
    check_eq("A_before_en_edge", int'(bus.A), 0);
    tick();
    tick();
    check_eq("A_two_after_en", int'(bus.A), 1);
    check_eq("R_before_first_upd", int'(bus.R), 0);
    wait_upd(ncyc);
    check_eq("first_upd_latency", ncyc + 2, W + 2);
    check_eq("first_R", int'(bus.R), 0);
    check_eq("first_count", int'(bus.count), 0);
    run_window(0, 0, 1, 0);
    check_win("no_pulse", 0, 0);

    run_window(3, 2, 10, 5);
    check_win("p3", 1, 3);
    run_window(6, 2, 10, 5);
    check_win("p6", 2, 6);
    run_window(9, 2, 10, 5);
    check_win("p9", 3, 9);
    run_window(20, 2, 4, 2);
    check_win("sat20", 3, 15);

    // Rise at offset 96 -> edge in last cycle; offset 97 -> edge in restart cycle.
    run_window(2, 50, 46, 3);
    check_win("edge_last", 1, 2);
    run_window(2, 50, 47, 3);
    check_win("edge_restart_old", 0, 1);
    run_window(0, 0, 1, 0);
    check_win("edge_restart_new", 0, 1);

    // en dropped mid-window.
    run_window(9, 2, 10, 5);
    check_win("pre_drop", 3, 9);
    repeat (30) tick();
    bus.en = 1'b0;
    tick();
    check_off("drop_mid");
    check_quiet("drop_mid_quiet");

    // en dropped in the last window cycle: no upd, no refresh.
    bus.en = 1'b1;
    wait_upd(ncyc);
    check_eq("reenable_latency", ncyc, W + 2);
    run_window(3, 2, 10, 5);
    check_win("pre_drop_last", 1, 3);
    repeat (W - 1) tick();
    bus.en = 1'b0;
    tick();
    check_off("drop_last");
    check_quiet("drop_last_quiet");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
